tone_player: RTL

//  Consumer side of the key-to-pitch path: takes the 20-bit half-period count produced by the note decoder
//  and synthesises a square-wave tone for the DE1-SoC audio codec. Generates the waveform, shapes

---
 rtl/tone_pkg.sv | 24 ++
 rtl/tone_player_if.sv | 24 ++
 rtl/tone_phase_gen.sv | 52 +++++
 rtl/tone_player.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared types and widths for the tone player: FSM states, sample/delay/amplitude widths
// and the amplitude-to-signed-sample conversion.
package tone_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ATTACK  = 2'd1,
        ST_SUSTAIN = 2'd2,
        ST_RELEASE = 2'd3
    } tone_state_e;

    localparam int SAMPLE_W = 32;
    localparam int DELAY_W  = 20;
    localparam int AMP_W    = 24;

    // phase=1 gives +amp, phase=0 gives -amp (two's complement of the zero-extended magnitude)
    function automatic logic [SAMPLE_W-1:0] signed_sample(input logic [AMP_W-1:0] amp,
                                                          input logic             phase);
        logic [SAMPLE_W-1:0] ext;
        ext = {{(SAMPLE_W-AMP_W){1'b0}}, amp};
        return phase ? ext : (~ext + SAMPLE_W'(1));
    endfunction

endpackage

// File: rtl/tone_player_if.sv
// Note-request and codec-write signals between the note decoder/codec side (master)
// and the tone player (slave).
interface tone_player_if;
    import tone_pkg::*;

    logic [DELAY_W-1:0]  delay;
    logic                note_on;
    logic                audio_out_allowed;
    logic [SAMPLE_W-1:0] left_channel_audio_out;
    logic [SAMPLE_W-1:0] right_channel_audio_out;
    logic                write_audio_out;
    logic                busy;

    modport master (
        output delay, note_on, audio_out_allowed,
        input  left_channel_audio_out, right_channel_audio_out, write_audio_out, busy
    );

    modport slave (
        input  delay, note_on, audio_out_allowed,
        output left_channel_audio_out, right_channel_audio_out, write_audio_out, busy
    );

endinterface

// File: rtl/tone_phase_gen.sv
// Square-wave phase generator: half-period counter with delay reload at each half-period
// boundary, so pitch changes never cut a half-period short.
module tone_phase_gen
    import tone_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               restart_i,
    input  logic [DELAY_W-1:0] delay_i,
    output logic               phase_o,
    output logic               silent_o
);

    logic [DELAY_W-1:0] active_q, active_d;
    logic [DELAY_W-1:0] cnt_q, cnt_d;
    logic               phase_q, phase_d;

    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        if (restart_i) begin
            active_d = delay_i;
            cnt_d    = '0;
            phase_d  = 1'b0;
        end else if (active_q != '0) begin
            if (cnt_q == active_q - DELAY_W'(1)) begin
                cnt_d    = '0;
                phase_d  = ~phase_q;
                active_d = delay_i;
            end else begin
                cnt_d = cnt_q + DELAY_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= '0;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
        end
    end

    assign phase_o  = phase_q;
    assign silent_o = (active_q == '0);

endmodule

// File: rtl/tone_player.sv
// Tone player: envelope FSM, sample-rate divider and codec write handshake around tone_phase_gen.
// Define TONE_ENVELOPE_EN for ramped attack/release; otherwise amplitude jumps in a single tick.
//
//  state   | meaning
//  IDLE    | silent, zero samples still written each tick
//  ATTACK  | amplitude ramping up toward AMP_MAX
//  SUSTAIN | amplitude held at AMP_MAX while note held
//  RELEASE | amplitude ramping down to 0 after key release
module tone_player
    import tone_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV   = 1042,
    parameter int unsigned AMP_MAX      = 10000000,
    parameter int unsigned ATTACK_STEP  = 100000,
    parameter int unsigned RELEASE_STEP = 20000
) (
    input  logic          clk,
    input  logic          reset,
    tone_player_if.slave  bus
);

`ifdef TONE_ENVELOPE_EN
    localparam bit ENV_EN = 1'b1;
`else
    localparam bit ENV_EN = 1'b0;
`endif
    localparam int unsigned ATK_INC = ENV_EN ? ATTACK_STEP  : AMP_MAX;
    localparam int unsigned REL_DEC = ENV_EN ? RELEASE_STEP : AMP_MAX;
    localparam int          DIV_W   = $clog2(SAMPLE_DIV + 1);

    localparam logic [AMP_W-1:0] AMP_TOP = AMP_W'(AMP_MAX);
    localparam logic [AMP_W:0]   ATK_V   = (AMP_W+1)'(ATK_INC);
    localparam logic [AMP_W-1:0] REL_V   = AMP_W'(REL_DEC);

    tone_state_e         state_q, state_d;
    logic [AMP_W-1:0]    amp_q, amp_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                pending_q, pending_d;
    logic [SAMPLE_W-1:0] pend_q, pend_d;
    logic [SAMPLE_W-1:0] out_q, out_d;
    logic                write_q, write_d;
    logic                tick, restart, phase, silent;

    tone_phase_gen u_phase (
        .clk       (clk),
        .reset     (reset),
        .restart_i (restart),
        .delay_i   (bus.delay),
        .phase_o   (phase),
        .silent_o  (silent)
    );

    always_comb begin
        state_d = state_q;
        amp_d   = amp_q;
        restart = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.note_on) begin
                    state_d = ST_ATTACK;
                    restart = 1'b1;
                end
            end
            ST_ATTACK: begin
                if (!bus.note_on) begin
                    state_d = ST_RELEASE;
                end else if (tick) begin
                    if (({1'b0, amp_q} + ATK_V) >= {1'b0, AMP_TOP}) begin
                        amp_d   = AMP_TOP;
                        state_d = ST_SUSTAIN;
                    end else begin
                        amp_d = amp_q + ATK_V[AMP_W-1:0];
                    end
                end
            end
            ST_SUSTAIN: begin
                if (!bus.note_on) state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                // re-attack keeps the current amplitude so the waveform does not click
                if (bus.note_on) begin
                    state_d = ST_ATTACK;
                    restart = 1'b1;
                end else if (tick) begin
                    if (amp_q <= REL_V) begin
                        amp_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        amp_d = amp_q - REL_V;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tick      = (div_q == DIV_W'(SAMPLE_DIV - 1));
        div_d     = tick ? '0 : div_q + DIV_W'(1);
        pending_d = pending_q;
        pend_d    = pend_q;
        out_d     = out_q;
        write_d   = 1'b0;
        if (pending_q && bus.audio_out_allowed) begin
            write_d   = 1'b1;
            out_d     = pend_q;
            pending_d = 1'b0;
        end
        // a tick overwrites any unsent sample; a write in the same cycle takes the old one
        if (tick) begin
            pending_d = 1'b1;
            pend_d    = silent ? '0 : signed_sample(amp_q, phase);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            amp_q     <= '0;
            div_q     <= '0;
            pending_q <= 1'b0;
            pend_q    <= '0;
            out_q     <= '0;
            write_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            amp_q     <= amp_d;
            div_q     <= div_d;
            pending_q <= pending_d;
            pend_q    <= pend_d;
            out_q     <= out_d;
            write_q   <= write_d;
        end
    end

    assign bus.left_channel_audio_out  = out_q;
    assign bus.right_channel_audio_out = out_q;
    assign bus.write_audio_out         = write_q;
    assign bus.busy                    = (state_q != ST_IDLE);

endmodule
